instr_exec_unit: RTL and testbench

//   Consumer end of the program counter: takes the 4-bit fetch address driven by the PC,

---
 rtl/instr_exec_unit.sv | 122 ++++++++++++
 tb/tb_instr_exec_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// Instruction execute unit: 16-entry program store, fetch/execute pipeline on an
// accumulator, and a sticky halt request back to the program counter.
module instr_exec_unit #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oStop,
  output logic [DATA_W-1:0] oAcc,
  output logic              oRetire,
  output logic [3:0]        oOpcode
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ir, ir_n;
  logic              fv, fv_n;
  logic [DATA_W-1:0] acc_n;
  logic              stop_n;
  logic              retire_n;
  logic [3:0]        opcode_n;
  logic [DATA_W-1:0] alu;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm;

  assign op  = ir[7:4];
  assign imm = {{(DATA_W-4){1'b0}}, ir[3:0]};

  // Program store; the read below sees pre-write contents on a same-address write.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (iWrEn) begin
      mem[iWrAddr] <= iWrData;
    end
  end

  always_comb begin
    alu = oAcc;
    case (op)
      4'h1:    alu = imm;
      4'h2:    alu = oAcc + imm;
      4'h3:    alu = oAcc - imm;
      4'h4:    alu = oAcc & imm;
      4'h5:    alu = oAcc | imm;
      4'h6:    alu = oAcc ^ imm;
      4'h7:    alu = oAcc << ir[2:0];
      4'h8:    alu = oAcc >> ir[2:0];
      default: alu = oAcc;
    endcase
  end

  always_comb begin
    state_n  = state;
    ir_n     = ir;
    fv_n     = fv;
    acc_n    = oAcc;
    stop_n   = oStop;
    retire_n = 1'b0;
    opcode_n = oOpcode;
    case (state)
      RUN: begin
        ir_n = mem[iAddress];
        fv_n = 1'b1;
        if (fv) begin
          retire_n = 1'b1;
          opcode_n = op;
          // HALT wins over the ALU decode and squashes the fetch in flight.
          if (op == HALT_OP) begin
            state_n = HALTED;
            stop_n  = 1'b1;
            fv_n    = 1'b0;
          end else begin
            acc_n = alu;
          end
        end
      end
      HALTED: begin
        fv_n = 1'b0;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state   <= RUN;
      ir      <= '0;
      fv      <= 1'b0;
      oAcc    <= '0;
      oStop   <= 1'b0;
      oRetire <= 1'b0;
      oOpcode <= '0;
    end else begin
      state   <= state_n;
      ir      <= ir_n;
      fv      <= fv_n;
      oAcc    <= acc_n;
      oStop   <= stop_n;
      oRetire <= retire_n;
      oOpcode <= opcode_n;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: program table, hand sequences for squash, async reset and
// read-during-write, and random traffic against a behavioural model.
module tb_instr_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] addr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       stop;
  logic [7:0] acc;
  logic       retire;
  logic [3:0] opcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_exec_unit #(.ADDR_W(4), .DATA_W(8), .HALT_OP(4'hF)) dut (
    .iClk(clk), .iReset(rst_n), .iAddress(addr), .iWrEn(wr_en), .iWrAddr(wr_addr),
    .iWrData(wr_data), .oStop(stop), .oAcc(acc), .oRetire(retire), .oOpcode(opcode)
  );

  // Behavioural model state
  logic [7:0] m_mem [16];
  logic [7:0] m_ir;
  bit         m_fv, m_halt, m_stop, m_ret;
  logic [7:0] m_acc;
  logic [3:0] m_op;

  typedef struct {
    logic [4:0][7:0] p;
    logic [7:0]      exp_acc;
    int              exp_ret;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic [7:0] a, b, c, d, e, input logic [7:0] x, input int r);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d; v.p[4] = e;
    v.exp_acc = x;
    v.exp_ret = r;
    return v;
  endfunction

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] ins);
    int unsigned av, imm, sh, res;
    av  = 32'(a);
    imm = 32'(ins[3:0]);
    sh  = imm % 8;
    case (ins[7:4])
      4'h1:    res = imm;
      4'h2:    res = av + imm;
      4'h3:    res = av + 256 - imm;
      4'h4:    res = av & imm;
      4'h5:    res = av | imm;
      4'h6:    res = av ^ imm;
      4'h7:    res = av * (32'd1 << sh);
      4'h8:    res = av / (32'd1 << sh);
      default: res = av;
    endcase
    return 8'(res % 256);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ir = 8'h00; m_fv = 0; m_halt = 0; m_stop = 0; m_ret = 0; m_acc = 8'h00; m_op = 4'h0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] a, input logic we,
                            input logic [3:0] wa, input logic [7:0] wd);
    if (!r) begin
      model_reset();
    end else begin
      m_ret = 0;
      if (!m_halt) begin
        if (m_fv) begin
          m_ret = 1;
          m_op  = m_ir[7:4];
          if (m_op == 4'hF) begin
            m_halt = 1; m_stop = 1; m_fv = 0;
          end else begin
            m_acc = ref_alu(m_acc, m_ir);
          end
        end
        if (!m_halt) begin
          m_ir = m_mem[a];
          m_fv = 1;
        end
      end
      if (we) m_mem[wa] = wd;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".acc"},    32'(acc),    32'(m_acc));
    chk({tag, ".stop"},   32'(stop),   32'(m_stop));
    chk({tag, ".retire"}, 32'(retire), 32'(m_ret));
    chk({tag, ".opcode"}, 32'(opcode), 32'(m_op));
  endtask

  task automatic step(input string tag);
    logic r, we;
    logic [3:0] a, wa;
    logic [7:0] wd;
    r = rst_n; a = addr; we = wr_en; wa = wr_addr; wd = wr_data;
    @(posedge clk);
    model_edge(r, a, we, wa, wd);
    #1;
    compare_all(tag);
  endtask

  // Reset, load five words while fetching the (NOP) word at 15, then run from 0.
  task automatic run_prog(input vec_t v, input string tag);
    int rets;
    bit seen;
    rst_n = 1'b0; wr_en = 1'b0; addr = 4'hF;
    step({tag, ".rst"});
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = v.p[i];
      step({tag, ".load"});
    end
    wr_en = 1'b0;
    addr  = 4'h0;
    step({tag, ".first"});
    rets = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      addr = addr + 4'd1;
      step({tag, ".run"});
      if (retire) rets++;
      if (stop) seen = 1;
    end
    chk({tag, ".halted"}, 32'(stop), 32'd1);
    chk({tag, ".final_acc"}, 32'(acc), 32'(v.exp_acc));
    chk({tag, ".retires"}, 32'(rets), 32'(v.exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(8'h15, 8'h23, 8'h31, 8'h00, 8'hF0, 8'h07, 5);
    vecs[1]  = mk(8'h1F, 8'h74, 8'h2F, 8'h2F, 8'hF0, 8'h0E, 5);
    vecs[2]  = mk(8'h13, 8'h34, 8'h00, 8'h00, 8'hF0, 8'hFF, 5);
    vecs[3]  = mk(8'h1F, 8'h74, 8'h5A, 8'h00, 8'hF0, 8'hFA, 5);
    vecs[4]  = mk(8'h1F, 8'h74, 8'h6F, 8'h00, 8'hF0, 8'hFF, 5);
    vecs[5]  = mk(8'h1F, 8'h74, 8'h89, 8'h00, 8'hF0, 8'h78, 5);
    vecs[6]  = mk(8'h19, 8'h7F, 8'h00, 8'h00, 8'hF0, 8'h80, 5);
    vecs[7]  = mk(8'h17, 8'hA0, 8'hE5, 8'h9F, 8'hF0, 8'h07, 5);
    vecs[8]  = mk(8'h1F, 8'h4A, 8'h00, 8'h00, 8'hF0, 8'h0A, 5);
    vecs[9]  = mk(8'h11, 8'h22, 8'hF0, 8'h19, 8'hF0, 8'h03, 3);
    vecs[10] = mk(8'h12, 8'hF0, 8'hF0, 8'h13, 8'hF0, 8'h02, 2);

    rst_n = 1'b0; addr = 4'h0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
    model_reset();

    // Reset with writes attempted: store stays cleared, outputs stay zero
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 15)); wr_data = 8'($urandom);
      step("reset_hold");
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr = addr + 4'd1;
      step("nop_run");
    end
    chk("nop_acc", 32'(acc), 32'd0);
    chk("nop_retire", 32'(retire), 32'd1);

    for (int t = 0; t < 11; t++) begin
      run_prog(vecs[t], $sformatf("vec%0d", t));
    end

    // Halted state holds: accumulator frozen, no retires, stop sticky
    run_prog(vecs[0], "hold");
    for (int i = 0; i < 20; i++) begin
      addr = addr + 4'd1;
      step("hold");
      chk("hold_acc", 32'(acc), 32'h07);
      chk("hold_retire", 32'(retire), 32'd0);
    end

    // Async reset between edges while halted, and again mid-run
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_halt_stop", 32'(stop), 32'd0);
    chk("async_halt_acc", 32'(acc), 32'd0);
    step("async_halt_edge");
    rst_n = 1'b1;
    step("async_release");
    chk("async_release_stop", 32'(stop), 32'd0);

    run_prog(vecs[1], "midrun");
    rst_n = 1'b0; step("midrun_rst");
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'h0; wr_data = 8'h1C; step("midrun_load");
    wr_en = 1'b0; addr = 4'h0;
    step("midrun_a"); step("midrun_b"); step("midrun_c");
    chk("midrun_acc_pre", 32'(acc), 32'h0C);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrun_async_acc", 32'(acc), 32'd0);
    chk("midrun_async_retire", 32'(retire), 32'd0);
    chk("midrun_async_opcode", 32'(opcode), 32'd0);
    step("midrun_async_edge");
    rst_n = 1'b1;
    step("midrun_after");
    chk("midrun_after_acc", 32'(acc), 32'd0);

    // Write to the address being fetched: IR takes the old word, next pass the new one
    rst_n = 1'b0; addr = 4'hF; step("rdw_rst");
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'h5; wr_data = 8'h11; step("rdw_load");
    wr_en = 1'b0; addr = 4'h5;
    step("rdw_f"); step("rdw_x");
    chk("rdw_acc_old0", 32'(acc), 32'h01);
    wr_en = 1'b1; wr_addr = 4'h5; wr_data = 8'h17; step("rdw_w");
    wr_en = 1'b0;
    step("rdw_old");
    chk("rdw_acc_old", 32'(acc), 32'h01);
    step("rdw_new");
    chk("rdw_acc_new", 32'(acc), 32'h07);

    // Random traffic: program writes in flight, PC wrap and jumps, occasional HALT
    for (int run = 0; run < 8; run++) begin
      rst_n = 1'b0; wr_en = 1'b0; step("rnd_rst");
      rst_n = 1'b1;
      addr = 4'($urandom_range(0, 15));
      for (int c = 0; c < 60; c++) begin
        wr_en   = ($urandom_range(0, 2) != 0);
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = 8'($urandom);
        if (wr_data[7:4] == 4'hF && $urandom_range(0, 5) != 0) wr_data[7:4] = 4'h2;
        if ($urandom_range(0, 9) == 0) addr = 4'($urandom_range(0, 15));
        else addr = addr + 4'd1;
        step($sformatf("rnd%0d", run));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
